out_serdes: RTL and testbench
=============================

# out_serdes

Output-direction IO cell primitive and counterpart of the input register path. It accepts a parallel word from fabric through a valid/ready handshake and serializes it LSB-first onto the pad data line, one bit per clk cycle. A per-word output-enable travels with the data. A combinational bypass lets fabric drive the pad directly. It sits between fabric routing and the VPR output pad.

## Interface
- WIDTH, 4, serialization factor; legal range 2..8.
- IDLE_VAL, 1'b0, level driven on dataOut when no word is being shifted.
- clk  input  1  shift clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- dataIn  input  WIDTH  parallel word from fabric; dataIn[0] is sent first.
- load  input  1  word valid; accepted on a posedge where load && ready.
- oe_in  input  1  output enable for the word being loaded; also the bypass OE.
- sel  input  1  1 = bypass: dataOut = dataIn[0], oe_out = oe_in (combinational); 0 = serialized path.
- ready  output  1  block can accept a word on the current edge.
- busy  output  1  a word is being driven (state SHIFT).
- word_done  output  1  high during the cycle the last bit (bit WIDTH-1) of a word is driven.
- dataOut  output  1  pad data.
- oe_out  output  1  pad output enable; 0 = tristate.

## Operation
- State machine with two states: IDLE and SHIFT.
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (width clog2(WIDTH), wraps at WIDTH-1), oe register oe_q.
- IDLE:
  - ready=1, busy=0.
  - Serial dataOut=IDLE_VAL, serial oe=0.
  - load on a posedge: sr<=dataIn, oe_q<=oe_in, cnt<=0, go to SHIFT.
- SHIFT:
  - Serial dataOut=sr[0], serial oe=oe_q.
  - Each posedge: sr shifts right by one (sr<=sr>>1) and cnt increments.
  - cnt==WIDTH-1 is the last bit. In that cycle, word_done=1 and ready=1.
  - On the last-bit edge with load=1: reload sr/oe_q, set cnt<=0, stay in SHIFT. There is no idle bit between words.
  - On the last-bit edge with load=0: go to IDLE.
- load while in SHIFT with cnt<WIDTH-1: ignored. ready=0, no state change, and the word is not queued.
- dataIn and oe_in are sampled only on an accepting edge. They may change freely at other times.
- sel affects only the output mux. The sequencer, ready, busy and word_done behave identically for sel=0 and sel=1.
  - Toggling sel mid-word does not corrupt the word. Deasserting sel resumes the serial stream at the current bit.
- Reset (async, any time, including mid-word):
  - state=IDLE, sr=0, cnt=0, oe_q=0.
  - ready=1, busy=0, word_done=0.
  - Serial dataOut=IDLE_VAL, oe_out=0 while sel=0.
  - The partial word is dropped.
- Deassertion of rst is synchronous to clk. The first accepted load is on the first posedge after rst falls.

## Timing
- Latency: for a word accepted at edge k, bit i appears on dataOut after edge k+i, for i=0..WIDTH-1. This is a one-edge load-to-first-bit latency.
- Throughput: one WIDTH-bit word every WIDTH cycles with back-to-back loads. 100% pad utilization.
- ready and word_done are combinational from state/cnt and are registered-state based. They have no combinational path from load.
- dataOut and oe_out come from registers when sel=0. They are combinational from dataIn[0] and oe_in when sel=1.
- Setup of dataIn, load, oe_in and sel is relative to posedge clk. Clock-to-out applies to dataOut, oe_out, ready, busy and word_done.

## Test plan
- Single word, WIDTH=4: dataIn=4'b1011, oe_in=1, load pulse.
  - Required: dataOut = 1,1,0,1 on the next 4 cycles and oe_out=1 throughout.
  - word_done is high on the 4th cycle.
  - The block then returns to IDLE with dataOut=IDLE_VAL and oe_out=0.
- Back-to-back: load 4'hA, then hold load=1 with 4'h5 until accepted.
  - Required: dataOut = 0,1,0,1,1,0,1,0 with no gap.
  - ready is high only in IDLE and in each last-bit cycle.
- Load while busy: assert load with 4'hF at cnt=1 of word 4'h0.
  - Required: ignored, output 0,0,0,0, then IDLE.
  - 4'hF is sent only if load is still high at the last-bit edge.
- Bypass: sel=1 mid-word, dataIn[0] toggling, oe_in=0.
  - Required: dataOut follows dataIn[0] and oe_out=0 combinationally.
  - After sel=0, the remaining bits of the serial word resume at the correct cnt.
- Reset mid-word: assert rst at cnt=2 of 4'b0110.
  - Required: immediately dataOut=IDLE_VAL, oe_out=0, ready=1, busy=0.
  - A new load after rst falls is serialized correctly from bit 0.
- WIDTH=2, IDLE_VAL=1: loads of 2'b01 and 2'b10 back-to-back.
  - Required: dataOut = 1,0,0,1, then constant 1 in IDLE.

Source files
------------

// File: rtl/out_serdes.sv
// out_serdes: output-direction IO serializer sitting between fabric routing
// and the VPR output pad.
//
// A parallel word is accepted from fabric through a load/ready handshake.
// It is shifted out LSB-first, one bit per clk, and an output enable travels
// with each word. When sel=1 a combinational bypass drives the pad directly
// from fabric. The sequencer keeps running underneath the bypass, so a word
// in flight is not disturbed.
//
// State table:
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no word in flight; pad gets IDLE_VAL with oe=0; ready=1
//   SHIFT | driving sr_q[0]; cnt_q is the index of the bit on the pad
//
// Parameters:
//   WIDTH     serialization factor (2..8)
//   IDLE_VAL  dataOut level on the serial path when no word is in flight
//
// Ports:
//   clk        shift clock, posedge
//   rst        asynchronous, active-high reset
//   dataIn     parallel word; dataIn[0] is sent first
//   load       word valid; accepted on a posedge where load && ready
//   oe_in      output enable for the loaded word; also the bypass OE
//   sel        1 = bypass (dataOut=dataIn[0], oe_out=oe_in), 0 = serial
//   ready      a word can be accepted on the coming edge
//   busy       a word is in flight (SHIFT)
//   word_done  the last bit of a word is on the pad this cycle
//   dataOut    pad data
//   oe_out     pad output enable, 0 = tristate

module out_serdes #(
  parameter int   WIDTH    = 4,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             load,
  input  logic             oe_in,
  input  logic             sel,
  output logic             ready,
  output logic             busy,
  output logic             word_done,
  output logic             dataOut,
  output logic             oe_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oe_q, oe_d;

  logic last_bit;
  logic ser_data;
  logic ser_oe;

  // ready/word_done depend only on registered state, never on load, so the
  // fabric can see ready before deciding to assert load.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign ready     = (state_q == IDLE) || last_bit;
  assign busy      = (state_q == SHIFT);
  assign word_done = last_bit;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = dataIn;
          oe_d    = oe_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (load) begin
            // Reload on the last-bit edge gives gapless back-to-back words.
            sr_d  = dataIn;
            oe_d  = oe_in;
            cnt_d = '0;
          end else begin
            sr_d    = '0;
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          // A load arriving mid-word is ignored and not queued.
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
    end
  end

  // The serial path is a pure function of registers; only the bypass leg
  // is combinational from fabric.
  assign ser_data = (state_q == SHIFT) ? sr_q[0] : IDLE_VAL;
  assign ser_oe   = (state_q == SHIFT) && oe_q;

  assign dataOut = sel ? dataIn[0] : ser_data;
  assign oe_out  = sel ? oe_in     : ser_oe;

endmodule

// File: tb/tb_out_serdes.sv
// Bench for out_serdes: a WIDTH=4/IDLE_VAL=0 instance and a
// WIDTH=2/IDLE_VAL=1 instance share clk and rst. Each scenario builds a
// per-cycle stimulus list, pushes the expected pad/handshake vector for each
// step onto a scoreboard queue, then drives the steps and pops/compares.
// Expected vector layout: {dataOut, oe_out, word_done, ready, busy}.

module tb_out_serdes;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d4;
  logic       ld4, oe4, sel4;
  logic       rdy4, bsy4, wd4, do4, oeo4;
  logic [1:0] d2;
  logic       ld2, oe2, sel2;
  logic       rdy2, bsy2, wd2, do2, oeo2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       wneg;
    logic       rst;
    logic       sel;
    logic       ld;
    logic       oe;
    logic [3:0] d;
    logic [4:0] e;
  } stim_t;

  stim_t      stq[$];
  logic [4:0] sbq[$];

  localparam logic [4:0] IDLE4 = 5'b00010;

  always #5 clk = ~clk;

  out_serdes #(.WIDTH(4), .IDLE_VAL(1'b0)) u4 (
    .clk(clk), .rst(rst), .dataIn(d4), .load(ld4), .oe_in(oe4), .sel(sel4),
    .ready(rdy4), .busy(bsy4), .word_done(wd4), .dataOut(do4), .oe_out(oeo4)
  );

  out_serdes #(.WIDTH(2), .IDLE_VAL(1'b1)) u2 (
    .clk(clk), .rst(rst), .dataIn(d2), .load(ld2), .oe_in(oe2), .sel(sel2),
    .ready(rdy2), .busy(bsy2), .word_done(wd2), .dataOut(do2), .oe_out(oeo2)
  );

  function automatic stim_t mk(input logic wneg, input logic r, input logic s,
                               input logic l, input logic o, input logic [3:0] d,
                               input logic [4:0] e);
    stim_t t;
    t.wneg = wneg; t.rst = r; t.sel = s; t.ld = l; t.oe = o; t.d = d; t.e = e;
    return t;
  endfunction

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    d4 = '0; ld4 = 0; oe4 = 0; sel4 = 0;
    d2 = '0; ld2 = 0; oe2 = 0; sel2 = 0;
    #3;
    obs = {do4, oeo4, wd4, rdy4, bsy4};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL reset_w4 got=%b exp=%b", obs, 5'b00010);
    end
    obs = {do2, oeo2, wd2, rdy2, bsy2};
    checks++;
    if (obs !== 5'b10010) begin
      errors++; $display("FAIL reset_w2 got=%b exp=%b", obs, 5'b10010);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the queued WIDTH=4 steps; every step pushes its expectation when
  // driven and pops it once outputs have settled.
  task automatic test_single();
    stim_t t;
    logic [4:0] obs, e;
    stq.delete();
    stq.push_back(mk(1, 0, 0, 1, 1, 4'b1011, IDLE4));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1011, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1011, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1011, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1011, 5'b11111));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1011, IDLE4));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1011, IDLE4));
    for (int n = 0; stq.size() > 0; n++) begin
      t = stq.pop_front();
      if (t.wneg) @(negedge clk); else #2;
      rst = t.rst; sel4 = t.sel; ld4 = t.ld; oe4 = t.oe; d4 = t.d;
      sbq.push_back(t.e);
      #1;
      e = sbq.pop_front();
      obs = {do4, oeo4, wd4, rdy4, bsy4};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL single step=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t t;
    logic [4:0] obs, e;
    logic [4:0] ev [10];
    ev = '{IDLE4, 5'b01001, 5'b11001, 5'b01001, 5'b11111,
           5'b11001, 5'b01001, 5'b11001, 5'b01111, IDLE4};
    stq.delete();
    stq.push_back(mk(1, 0, 0, 1, 1, 4'hA, ev[0]));
    for (int i = 1; i < 5; i++) stq.push_back(mk(1, 0, 0, 1, 1, 4'h5, ev[i]));
    for (int i = 5; i < 10; i++) stq.push_back(mk(1, 0, 0, 0, 1, 4'h5, ev[i]));
    for (int n = 0; stq.size() > 0; n++) begin
      t = stq.pop_front();
      if (t.wneg) @(negedge clk); else #2;
      rst = t.rst; sel4 = t.sel; ld4 = t.ld; oe4 = t.oe; d4 = t.d;
      sbq.push_back(t.e);
      #1;
      e = sbq.pop_front();
      obs = {do4, oeo4, wd4, rdy4, bsy4};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL back_to_back step=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_load_while_busy();
    stim_t t;
    logic [4:0] obs, e;
    stq.delete();
    // Load at cnt=1 then dropped: ignored.
    stq.push_back(mk(1, 0, 0, 1, 1, 4'h0, IDLE4));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'h0, 5'b01001));
    stq.push_back(mk(1, 0, 0, 1, 1, 4'hF, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'hF, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'hF, 5'b01111));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'hF, IDLE4));
    // Load at cnt=1 held through the last-bit edge: 4'hF follows.
    stq.push_back(mk(1, 0, 0, 1, 1, 4'h0, IDLE4));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'h0, 5'b01001));
    stq.push_back(mk(1, 0, 0, 1, 1, 4'hF, 5'b01001));
    stq.push_back(mk(1, 0, 0, 1, 1, 4'hF, 5'b01001));
    stq.push_back(mk(1, 0, 0, 1, 1, 4'hF, 5'b01111));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'h0, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'h0, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'h0, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'h0, 5'b11111));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'h0, IDLE4));
    for (int n = 0; stq.size() > 0; n++) begin
      t = stq.pop_front();
      if (t.wneg) @(negedge clk); else #2;
      rst = t.rst; sel4 = t.sel; ld4 = t.ld; oe4 = t.oe; d4 = t.d;
      sbq.push_back(t.e);
      #1;
      e = sbq.pop_front();
      obs = {do4, oeo4, wd4, rdy4, bsy4};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL load_busy step=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_bypass();
    stim_t t;
    logic [4:0] obs, e;
    stq.delete();
    stq.push_back(mk(1, 0, 0, 1, 1, 4'b1001, IDLE4));
    stq.push_back(mk(1, 0, 1, 0, 0, 4'b1110, 5'b00001));
    stq.push_back(mk(0, 0, 1, 0, 0, 4'b1111, 5'b10001));
    stq.push_back(mk(0, 0, 1, 0, 1, 4'b1111, 5'b11001));
    stq.push_back(mk(1, 0, 1, 0, 0, 4'b0000, 5'b00001));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 5'b11111));
    stq.push_back(mk(1, 0, 0, 0, 0, 4'b0000, IDLE4));
    for (int n = 0; stq.size() > 0; n++) begin
      t = stq.pop_front();
      if (t.wneg) @(negedge clk); else #2;
      rst = t.rst; sel4 = t.sel; ld4 = t.ld; oe4 = t.oe; d4 = t.d;
      sbq.push_back(t.e);
      #1;
      e = sbq.pop_front();
      obs = {do4, oeo4, wd4, rdy4, bsy4};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL bypass step=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    stim_t t;
    logic [4:0] obs, e;
    stq.delete();
    stq.push_back(mk(1, 0, 0, 1, 1, 4'b0110, IDLE4));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b0110, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b0110, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b0110, 5'b11001));
    stq.push_back(mk(0, 1, 0, 0, 1, 4'b0110, IDLE4));
    stq.push_back(mk(1, 0, 0, 1, 1, 4'b1100, IDLE4));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1100, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1100, 5'b01001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1100, 5'b11001));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1100, 5'b11111));
    stq.push_back(mk(1, 0, 0, 0, 1, 4'b1100, IDLE4));
    for (int n = 0; stq.size() > 0; n++) begin
      t = stq.pop_front();
      if (t.wneg) @(negedge clk); else #2;
      rst = t.rst; sel4 = t.sel; ld4 = t.ld; oe4 = t.oe; d4 = t.d;
      sbq.push_back(t.e);
      #1;
      e = sbq.pop_front();
      obs = {do4, oeo4, wd4, rdy4, bsy4};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL reset_mid step=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_width2();
    logic [4:0] obs, e;
    logic       ldv [7];
    logic [1:0] dv  [7];
    logic [4:0] ev  [7];
    ldv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    dv  = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    ev  = '{5'b10010, 5'b11001, 5'b01111, 5'b01001, 5'b11111, 5'b10010, 5'b10010};
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      ld2 = ldv[n]; d2 = dv[n]; oe2 = 1'b1; sel2 = 1'b0;
      sbq.push_back(ev[n]);
      #1;
      e = sbq.pop_front();
      obs = {do2, oeo2, wd2, rdy2, bsy2};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL width2 step=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_load_while_busy();
    test_bypass();
    test_reset_mid_word();
    test_width2();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got=%0d exp=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
